// File: rtl/fpu_spi_pkg.sv
// fpu_spi_pkg
// Shared definitions for the SPI front end of the FPU:
//   FRAME_W   - default command frame width {op, a, b}.
//   STATUS_W  - width of the status byte returned on MISO.
//   ST_*      - bit positions inside the status byte; the low five bits hold
//               the IEEE flags {NV,DZ,OF,UF,NX} of the last result.
//   link_state_t / job_state_t - states of the SPI link and FPU job FSMs.
package fpu_spi_pkg;

    localparam int FRAME_W  = 72;
    localparam int STATUS_W = 8;

    localparam int ST_DONE  = 7;
    localparam int ST_BUSY  = 6;
    localparam int ST_ERR   = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } link_state_t;

    typedef enum logic [1:0] {
        FREE,
        ISSUE,
        WAIT
    } job_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Brings one asynchronous pin into the clk domain through SYNC_STAGES flops
// and compares against one more flop to find edges.
// Ports:
//   clk, rst - system clock, asynchronous active-high reset
//   din      - raw asynchronous input
//   level    - synchronized level
//   rise     - one-cycle pulse on a synchronized 0->1 transition
//   fall     - one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {SYNC_STAGES{RST_VAL}};
            prev_reg <= RST_VAL;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_fpu_frontend.sv
// spi_fpu_frontend
// SPI mode-0 slave that receives one {op, a, b} command per CS_N assertion,
// hands it to the FPU core over valid/ready, captures the result and returns
// {status, result} on MISO during the following frame.
// Ports:
//   clk, rst                 - system clock, asynchronous active-high reset
//   SCLK, CS_N, MOSI         - raw SPI pins (asynchronous to clk)
//   MISO                     - registered serial readout
//   req_valid, req_ready     - request handshake to the FPU core
//   req_op, req_a, req_b     - request payload, held while req_valid is high
//   res_valid                - one-cycle result strobe from the core
//   res_data, res_flags      - result word and IEEE flags {NV,DZ,OF,UF,NX}
module spi_fpu_frontend
    import fpu_spi_pkg::*;
#(
    parameter int OP_W        = 8,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              CS_N,
    input  logic              MOSI,
    output logic              MISO,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [OP_W-1:0]   req_op,
    output logic [DATA_W-1:0] req_a,
    output logic [DATA_W-1:0] req_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic [4:0]        res_flags
);

    localparam int FRAME_LEN = OP_W + 2 * DATA_W;
    localparam int TX_W      = STATUS_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level_unused, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic mosi_bit;

    link_state_t            link_state;
    job_state_t             job_state;
    logic [CNT_W-1:0]       bit_count;
    logic [FRAME_LEN-1:0]   shift_reg;
    logic [TX_W-1:0]        tx_reg;
    logic                   err_reg;
    logic                   done_reg;
    logic [4:0]             flags_reg;
    logic [DATA_W-1:0]      result_reg;
    logic [STATUS_W-1:0]    status;
    logic                   tx_load;
    logic                   frame_ok;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (SCLK),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // CS_N resets to "selected" so a CS_N already low at reset release is not
    // mistaken for a fresh select; the link only starts on a genuine fall.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (CS_N),
        .level (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as the SCLK synchronizer so MOSI lines up with sclk_rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync_reg <= '0;
        end else begin
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
        end
    end
    assign mosi_bit = mosi_sync_reg[SYNC_STAGES-1];

    always_comb begin
        status          = '0;
        status[ST_DONE] = done_reg;
        status[ST_BUSY] = (job_state != FREE);
        status[ST_ERR]  = err_reg;
        status[4:0]     = flags_reg;
    end

    assign tx_load  = (link_state == IDLE) && cs_fall;
    assign frame_ok = (link_state == CHECK) && (bit_count == CNT_FULL) && (job_state == FREE);
    assign MISO     = tx_reg[TX_W-1];

    // Link FSM: frame reception, length check and MISO shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_state <= IDLE;
            bit_count  <= '0;
            shift_reg  <= '0;
            tx_reg     <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (link_state)
                IDLE: begin
                    if (cs_fall) begin
                        link_state <= SHIFT;
                        bit_count  <= '0;
                        tx_reg     <= {status, result_reg};
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        link_state <= CHECK;
                        tx_reg     <= '0;   // MISO idles low while deselected
                    end else begin
                        if (sclk_rise) begin
                            shift_reg <= {shift_reg[FRAME_LEN-2:0], mosi_bit};
                            if (bit_count != CNT_SAT) begin
                                bit_count <= bit_count + CNT_W'(1);
                            end
                        end
                        if (sclk_fall) begin
                            tx_reg <= {tx_reg[TX_W-2:0], 1'b0};
                        end
                    end
                end
                CHECK: begin
                    link_state <= IDLE;
                    err_reg    <= ~frame_ok;
                end
                default: link_state <= IDLE;
            endcase
        end
    end

    // Job FSM: request issue, handshake and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_state  <= FREE;
            req_valid  <= 1'b0;
            req_op     <= '0;
            req_a      <= '0;
            req_b      <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
            done_reg   <= 1'b0;
        end else begin
            case (job_state)
                FREE: begin
                    if (frame_ok) begin
                        job_state                <= ISSUE;
                        req_valid                <= 1'b1;
                        {req_op, req_a, req_b}   <= shift_reg;
                    end
                end
                ISSUE: begin
                    if (req_ready) begin
                        job_state <= WAIT;
                        req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (res_valid) begin
                        job_state  <= FREE;
                        result_reg <= res_data;
                        flags_reg  <= res_flags;
                    end
                end
                default: job_state <= FREE;
            endcase

            // A result arriving in the same cycle as a readout load wins, so
            // it is still reported on the next frame.
            if ((job_state == WAIT) && res_valid) begin
                done_reg <= 1'b1;
            end else if (tx_load) begin
                done_reg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_fpu_frontend.md
# spi_fpu_frontend

SPI-slave front end that converts the chip's raw SPI pins into FPU operation requests and returns FPU results on MISO. It synchronizes SCLK/CS_N/MOSI into the `clk` domain, deserializes one 72-bit command frame per CS_N assertion, and issues it to the FPU core over a valid/ready handshake. It captures the core's result and flags for readout on the next frame. It sits between the chip pins and the pipelined FPU datapath inside the SPI-attached FPU.

## Interface
- `OP_W`, 8: opcode width.
- `DATA_W`, 32: operand/result width.
- `SYNC_STAGES`, 2: synchronizer flops per SPI input (≥2).
- `clk` in 1: system clock; SCLK must be ≤ clk/8.
- `rst` in 1: asynchronous, active-high reset.
- `SCLK`, `CS_N`, `MOSI` in 1: raw SPI pins, asynchronous to `clk`.
- `MISO` out 1: serial readout, registered.
- `req_valid` out 1 / `req_ready` in 1: request handshake.
- `req_op` out OP_W, `req_a` out DATA_W, `req_b` out DATA_W: request payload, stable while `req_valid` is high.
- `res_valid` in 1: one-cycle result strobe from the core.
- `res_data` in DATA_W, `res_flags` in 5: result and IEEE flags {NV,DZ,OF,UF,NX}.

## Operation
- SPI mode 0, MSB first. MOSI is sampled on a synchronized SCLK rise. MISO advances on a synchronized SCLK fall.
- Command frame, FRAME_W = OP_W + 2·DATA_W = 72 bits: {op, a, b}.
- Link FSM:
  - IDLE → SHIFT on synchronized CS_N fall.
  - SHIFT: shift in MOSI and count bits; the count saturates at FRAME_W+1.
  - SHIFT → CHECK on CS_N rise.
  - CHECK → IDLE after one cycle.
  - SCLK edges while CS_N is high are ignored.
- CHECK accepts the frame only if count == FRAME_W and the job FSM is FREE. Otherwise the frame is dropped and `err` is set. An accepted frame clears `err`.
- Job FSM:
  - FREE → ISSUE on an accepted frame; op/a/b are latched and `req_valid` goes high.
  - ISSUE → WAIT when `req_valid && req_ready`.
  - WAIT → FREE on `res_valid`; `res_data`/`res_flags` are captured and `done` is set.
  - `res_valid` in FREE or ISSUE is ignored.
- Status byte = {done, busy, err, flags[4:0]}, where busy = job FSM ≠ FREE.
- Readout:
  - On synchronized CS_N fall, the TX shift register loads {status, result}, 40 bits, and `done` clears.
  - MISO presents the MSB immediately and shifts on each SCLK fall.
  - Bits beyond 40 read 0.
  - MISO = 0 while CS_N is high.
- `done` set by `res_valid` in the same cycle as a load is still set after that load.
- Reset values: `MISO`=0, `req_valid`=0, `req_op`/`req_a`/`req_b`=0, result=0, status=0, both FSMs idle (IDLE/FREE).
- Reset mid-frame aborts everything. If CS_N is low at reset release, the block waits for a new CS_N fall; no partial frame is accepted.

## Timing
- Edge-detect latency: a pin transition is seen as a synchronized edge SYNC_STAGES+1 clk edges after the first clk edge that samples the new level.
- `req_valid` rises 2 cycles after the CS_N-rise edge detect (CHECK, then the ISSUE register).
- `req_valid` stays high until the handshake completes and falls the cycle after.
- MISO update lags the SCLK fall edge detect by 1 cycle. Data is valid well before the next SCLK rise given SCLK ≤ clk/8.
- Request-to-result is unbounded; the core's latency is not assumed.

## Structure
- `fpu_spi_pkg`:
  - FRAME_W and STATUS_W = 8.
  - Status bit indices.
  - `link_state_t` {IDLE, SHIFT, CHECK}.
  - `job_state_t` {FREE, ISSUE, WAIT}.
- Sub-module `spi_sync_edge`: SYNC_STAGES-flop synchronizer plus previous-level flop, outputting the synced level, `rise`, and `fall`. It is instantiated for SCLK and CS_N; MOSI uses the synchronizer only.

## Test plan
- Valid frame: op=0x01, a=0x3F800000, b=0x40000000, `req_ready` held high. Expect one `req_valid` pulse with the exact payload. Then `res_valid` with 0x40400000, flags=0. The next frame reads status 0x80 followed by 0x40400000 on MISO, and a subsequent read gives status 0x00.
- Backpressure: `req_ready` held low 10 cycles. `req_valid` and the payload stay stable; the handshake completes on the first ready cycle; busy=1 reads as status 0x40.
- Short frame of 71 bits and long frame of 80 bits: no `req_valid`; status reads 0x20; the next valid frame clears `err`.
- Overrun: second valid frame while in WAIT is dropped; the original request is unaffected; status reads 0x60.
- Reset asserted mid-SHIFT at bit 30 with CS_N still low: all outputs return to reset values; remaining SCLKs produce no request; the next full frame works.
- Coincident `res_valid` and CS_N-fall load: MISO status shows done=0, the following read shows done=1 with the new result.
